// File: rtl/if_fetch_gen.sv
// if_fetch_gen: front-end fetch generator.
// Owns the fetch PC and issues 8-byte-aligned requests to the I-cache. Each
// response is turned into a two-slot bundle (inst/pc/valid per slot) for the
// IF stage register. The bundle is held under downstream stall. A redirect
// flushes the bundle, and the DROP state swallows any response that is still
// owed for a request that has been abandoned.
module if_fetch_gen #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_ack_i,
    input  logic        icache_rvalid_i,
    input  logic [63:0] icache_rdata_i,
    output logic [31:0] inst_1_o,
    output logic [31:0] inst_2_o,
    output logic [31:0] pc_1_o,
    output logic [31:0] pc_2_o,
    output logic        valid_1_o,
    output logic        valid_2_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_1_d, inst_2_d, pc_1_d, pc_2_d;
    logic        valid_1_d, valid_2_d;

    // Redirect targets are word aligned, so the two low bits are dropped.
    logic [1:0]  unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc_i[1:0];

    // Request and fetch address come straight from registered state.
    assign icache_req_o  = (state_q == S_REQ);
    assign icache_addr_o = {pc_q[31:3], 3'b000};

    // Next-state, next-PC and next-bundle logic.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_1_d  = inst_1_o;
        inst_2_d  = inst_2_o;
        pc_1_d    = pc_1_o;
        pc_2_d    = pc_2_o;
        valid_1_d = valid_1_o;
        valid_2_d = valid_2_o;

        if (redirect_valid_i) begin
            // Flush wins over everything, stall included. Only the question of
            // whether a response is still owed decides where to go next.
            pc_d      = {redirect_pc_i[31:2], 2'b00};
            inst_1_d  = '0;
            inst_2_d  = '0;
            pc_1_d    = '0;
            pc_2_d    = '0;
            valid_1_d = 1'b0;
            valid_2_d = 1'b0;
            unique case (state_q)
                S_REQ:   state_d = icache_ack_i    ? S_DROP : S_REQ;
                S_WAIT:  state_d = icache_rvalid_i ? S_REQ  : S_DROP;
                S_OUT:   state_d = S_REQ;
                S_DROP:  state_d = icache_rvalid_i ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (icache_ack_i) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (icache_rvalid_i) begin
                        state_d   = S_OUT;
                        valid_1_d = 1'b1;
                        pc_1_d    = pc_q;
                        if (!pc_q[2]) begin
                            // Aligned PC: both words of the line are useful.
                            inst_1_d  = icache_rdata_i[31:0];
                            inst_2_d  = icache_rdata_i[63:32];
                            pc_2_d    = pc_q + 32'd4;
                            valid_2_d = 1'b1;
                        end else begin
                            // PC in the upper word: only that word is useful.
                            inst_1_d  = icache_rdata_i[63:32];
                            inst_2_d  = '0;
                            pc_2_d    = '0;
                            valid_2_d = 1'b0;
                        end
                        // Next line; the PC wraps silently at 2^32.
                        pc_d = {pc_q[31:3] + 29'd1, 3'b000};
                    end
                end
                S_OUT: begin
                    if (!stall_i) begin
                        state_d   = S_REQ;
                        valid_1_d = 1'b0;
                        valid_2_d = 1'b0;
                    end
                end
                S_DROP: begin
                    if (icache_rvalid_i) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State, PC and output bundle registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: reset is sampled on the clock edge. There is no array
            // storage here, so every register is reset to a known value.
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_1_o  <= '0;
            inst_2_o  <= '0;
            pc_1_o    <= '0;
            pc_2_o    <= '0;
            valid_1_o <= 1'b0;
            valid_2_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_1_o  <= inst_1_d;
            inst_2_o  <= inst_2_d;
            pc_1_o    <= pc_1_d;
            pc_2_o    <= pc_2_d;
            valid_1_o <= valid_1_d;
            valid_2_o <= valid_2_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_gen.sv
// Testbench for if_fetch_gen. Inputs change and outputs are sampled on the
// falling edge. Expected bundles are computed from the fetch PC that the bench
// tracks. They are pushed to a scoreboard when the response is driven and
// popped when the bundle appears on the outputs.
module tb_if_fetch_gen;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    typedef struct packed {
        logic [31:0] inst1;
        logic [31:0] inst2;
        logic [31:0] pc1;
        logic [31:0] pc2;
        logic        v1;
        logic        v2;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_ack_i;
    logic        icache_rvalid_i;
    logic [63:0] icache_rdata_i;
    logic [31:0] inst_1_o, inst_2_o, pc_1_o, pc_2_o;
    logic        valid_1_o, valid_2_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    bundle_t     sb_q[$];
    bundle_t     exp_b;
    logic [31:0] exp_pc;

    if_fetch_gen #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .stall_i          (stall_i),
        .icache_req_o     (icache_req_o),
        .icache_addr_o    (icache_addr_o),
        .icache_ack_i     (icache_ack_i),
        .icache_rvalid_i  (icache_rvalid_i),
        .icache_rdata_i   (icache_rdata_i),
        .inst_1_o         (inst_1_o),
        .inst_2_o         (inst_2_o),
        .pc_1_o           (pc_1_o),
        .pc_2_o           (pc_2_o),
        .valid_1_o        (valid_1_o),
        .valid_2_o        (valid_2_o)
    );

    always #5 clk = ~clk;

    // Reference model of the bundle built from one cache line.
    function automatic bundle_t make_exp(input logic [31:0] pc, input logic [63:0] rd);
        bundle_t b;
        b.v1  = 1'b1;
        b.pc1 = pc;
        if (pc[2] == 1'b0) begin
            b.inst1 = rd[31:0];
            b.inst2 = rd[63:32];
            b.pc2   = pc + 32'd4;
            b.v2    = 1'b1;
        end else begin
            b.inst1 = rd[63:32];
            b.inst2 = 32'h0;
            b.pc2   = 32'h0;
            b.v2    = 1'b0;
        end
        return b;
    endfunction

    function automatic bundle_t observed();
        bundle_t b;
        b = '{inst1: inst_1_o, inst2: inst_2_o, pc1: pc_1_o, pc2: pc_2_o,
              v1: valid_1_o, v2: valid_2_o};
        return b;
    endfunction

    // Drives one accepted request and its response. Called on a falling edge
    // with the DUT in REQ. Returns on the falling edge where the bundle is
    // visible on the outputs.
    task automatic do_fetch(input logic [63:0] rd, input int ack_wait, input int rv_wait);
        repeat (ack_wait) @(negedge clk);
        icache_ack_i = 1'b1;
        @(negedge clk);
        icache_ack_i = 1'b0;
        repeat (rv_wait) @(negedge clk);
        icache_rvalid_i = 1'b1;
        icache_rdata_i  = rd;
        sb_q.push_back(make_exp(exp_pc, rd));
        exp_pc = {exp_pc[31:3] + 29'd1, 3'b000};
        @(negedge clk);
        icache_rvalid_i = 1'b0;
        icache_rdata_i  = {$urandom, $urandom};
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = target;
        exp_pc           = {target[31:2], 2'b00};
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (observed() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", observed());
        end
        n_cmp++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, RESET_PC}) begin
            n_bad++;
            $display("FAIL reset_req got req=%b addr=%h want req=1 addr=%h",
                     icache_req_o, icache_addr_o, RESET_PC);
        end
        rst    = 1'b1;
        exp_pc = RESET_PC;
        @(negedge clk);
    endtask

    task automatic test_basic_fetch();
        n_cmp++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'h1c00_0000}) begin
            n_bad++;
            $display("FAIL basic_addr got req=%b addr=%h want req=1 addr=1c000000",
                     icache_req_o, icache_addr_o);
        end
        do_fetch(64'hbbbb_0002_aaaa_0001, 0, 0);
        exp_b = sb_q.pop_front();
        n_cmp++;
        if (observed() !== exp_b) begin
            n_bad++;
            $display("FAIL basic_bundle got %h want %h", observed(), exp_b);
        end
        @(negedge clk);
        n_cmp++;
        if ({valid_1_o, valid_2_o, icache_req_o, icache_addr_o} !== {3'b001, 32'h1c00_0008}) begin
            n_bad++;
            $display("FAIL basic_next got v=%b%b req=%b addr=%h want v=00 req=1 addr=1c000008",
                     valid_1_o, valid_2_o, icache_req_o, icache_addr_o);
        end
    endtask

    task automatic test_odd_redirect();
        redirect_to(32'h1c00_0104);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        n_cmp++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'h1c00_0100}) begin
            n_bad++;
            $display("FAIL odd_addr got req=%b addr=%h want req=1 addr=1c000100",
                     icache_req_o, icache_addr_o);
        end
        do_fetch(64'h1111_2222_3333_4444, 1, 0);
        exp_b = sb_q.pop_front();
        n_cmp++;
        if (observed() !== exp_b) begin
            n_bad++;
            $display("FAIL odd_bundle got %h want %h", observed(), exp_b);
        end
        @(negedge clk);
        n_cmp++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'h1c00_0108}) begin
            n_bad++;
            $display("FAIL odd_next got req=%b addr=%h want req=1 addr=1c000108",
                     icache_req_o, icache_addr_o);
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        do_fetch(64'hcafe_0001_beef_0002, 0, 1);
        exp_b = sb_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({observed(), icache_req_o} !== {exp_b, 1'b0}) begin
                n_bad++;
                $display("FAIL stall_hold%0d got %h req=%b want %h req=0",
                         i, observed(), icache_req_o, exp_b);
            end
            if (i < 3) @(negedge clk);
        end
        stall_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({valid_1_o, valid_2_o, icache_req_o, icache_addr_o} !== {3'b001, exp_pc}) begin
            n_bad++;
            $display("FAIL stall_release got v=%b%b req=%b addr=%h want v=00 req=1 addr=%h",
                     valid_1_o, valid_2_o, icache_req_o, icache_addr_o, exp_pc);
        end
    endtask

    task automatic test_redirect_wait();
        icache_ack_i = 1'b1;
        @(negedge clk);
        icache_ack_i = 1'b0;
        redirect_to(32'h1c00_0200);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        n_cmp++;
        if ({valid_1_o, icache_req_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL wait_drop got v1=%b req=%b want v1=0 req=0", valid_1_o, icache_req_o);
        end
        @(negedge clk);
        icache_rvalid_i = 1'b1;
        icache_rdata_i  = 64'hdead_dead_dead_dead;
        @(negedge clk);
        icache_rvalid_i = 1'b0;
        n_cmp++;
        if ({valid_1_o, valid_2_o, icache_req_o, icache_addr_o} !== {3'b001, 32'h1c00_0200}) begin
            n_bad++;
            $display("FAIL wait_after got v=%b%b req=%b addr=%h want v=00 req=1 addr=1c000200",
                     valid_1_o, valid_2_o, icache_req_o, icache_addr_o);
        end
    endtask

    task automatic test_coincident();
        // Redirect together with the response in WAIT.
        icache_ack_i = 1'b1;
        @(negedge clk);
        icache_ack_i    = 1'b0;
        icache_rvalid_i = 1'b1;
        icache_rdata_i  = 64'hbad0_bad0_bad0_bad0;
        redirect_to(32'h1c00_0300);
        @(negedge clk);
        icache_rvalid_i  = 1'b0;
        redirect_valid_i = 1'b0;
        n_cmp++;
        if ({valid_1_o, icache_req_o, icache_addr_o} !== {2'b01, 32'h1c00_0300}) begin
            n_bad++;
            $display("FAIL coinc_rvalid got v1=%b req=%b addr=%h want v1=0 req=1 addr=1c000300",
                     valid_1_o, icache_req_o, icache_addr_o);
        end
        // Redirect together with the ack in REQ: the owed response is swallowed.
        icache_ack_i = 1'b1;
        redirect_to(32'h1c00_0404);
        @(negedge clk);
        icache_ack_i     = 1'b0;
        redirect_valid_i = 1'b0;
        n_cmp++;
        if (icache_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL coinc_ack_req got req=%b want 0", icache_req_o);
        end
        @(negedge clk);
        icache_rvalid_i = 1'b1;
        icache_rdata_i  = 64'hbad1_bad1_bad1_bad1;
        @(negedge clk);
        icache_rvalid_i = 1'b0;
        n_cmp++;
        if ({valid_1_o, icache_req_o, icache_addr_o} !== {2'b01, 32'h1c00_0400}) begin
            n_bad++;
            $display("FAIL coinc_ack_after got v1=%b req=%b addr=%h want v1=0 req=1 addr=1c000400",
                     valid_1_o, icache_req_o, icache_addr_o);
        end
        do_fetch(64'h5555_6666_7777_8888, 0, 0);
        exp_b = sb_q.pop_front();
        n_cmp++;
        if (observed() !== exp_b) begin
            n_bad++;
            $display("FAIL coinc_refetch got %h want %h", observed(), exp_b);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        redirect_to(32'hffff_fffb);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        do_fetch(64'h0bad_f00d_0123_4567, 0, 0);
        exp_b = sb_q.pop_front();
        n_cmp++;
        if (observed() !== exp_b) begin
            n_bad++;
            $display("FAIL wrap_bundle got %h want %h", observed(), exp_b);
        end
        @(negedge clk);
        n_cmp++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'h0000_0000}) begin
            n_bad++;
            $display("FAIL wrap_addr got req=%b addr=%h want req=1 addr=00000000",
                     icache_req_o, icache_addr_o);
        end
    endtask

    task automatic test_back_to_back();
        redirect_to(32'h1c00_1000);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_fetch({$urandom, $urandom}, i % 2, i);
            exp_b = sb_q.pop_front();
            n_cmp++;
            if (observed() !== exp_b) begin
                n_bad++;
                $display("FAIL b2b_bundle%0d got %h want %h", i, observed(), exp_b);
            end
            @(negedge clk);
            n_cmp++;
            if ({valid_1_o, icache_req_o, icache_addr_o} !== {2'b01, exp_pc}) begin
                n_bad++;
                $display("FAIL b2b_next%0d got v1=%b req=%b addr=%h want v1=0 req=1 addr=%h",
                         i, valid_1_o, icache_req_o, icache_addr_o, exp_pc);
            end
        end
    endtask

    task automatic test_reset_in_out();
        stall_i = 1'b1;
        do_fetch(64'h9999_aaaa_bbbb_cccc, 0, 0);
        exp_b = sb_q.pop_front();
        n_cmp++;
        if (observed() !== exp_b) begin
            n_bad++;
            $display("FAIL rstout_bundle got %h want %h", observed(), exp_b);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({observed(), icache_req_o, icache_addr_o} !== {'0, 1'b1, RESET_PC}) begin
            n_bad++;
            $display("FAIL rstout_state got %h req=%b addr=%h want 0 req=1 addr=%h",
                     observed(), icache_req_o, icache_addr_o, RESET_PC);
        end
        rst     = 1'b1;
        stall_i = 1'b0;
        exp_pc  = RESET_PC;
        @(negedge clk);
        do_fetch(64'h0000_0042_0000_0041, 0, 0);
        exp_b = sb_q.pop_front();
        n_cmp++;
        if (observed() !== exp_b) begin
            n_bad++;
            $display("FAIL rstout_restart got %h want %h", observed(), exp_b);
        end
        @(negedge clk);
    endtask

    initial begin
        rst              = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        stall_i          = 1'b0;
        icache_ack_i     = 1'b0;
        icache_rvalid_i  = 1'b0;
        icache_rdata_i   = '0;
        exp_pc           = RESET_PC;
        test_reset();
        test_basic_fetch();
        test_odd_redirect();
        test_stall();
        test_redirect_wait();
        test_coincident();
        test_wrap();
        test_back_to_back();
        test_reset_in_out();
        n_cmp++;
        if (sb_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_left got %0d entries want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
